// File: rtl/dmac_cfg_regbank.sv
// dmac_cfg_regbank: DMA config registers with byte strobes, start pulses, W1C interrupts and error flagging
module dmac_cfg_regbank #(
    parameter int          NUM_CH  = 4,
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wren_i,
    input  logic                 rden_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wstrb_i,
    output logic [31:0]          rdata_o,
    output logic                 rvalid_o,
    output logic                 err_o,
    output logic [NUM_CH*32-1:0] src_addr_o,
    output logic [NUM_CH*32-1:0] dst_addr_o,
    output logic [NUM_CH*16-1:0] byte_len_o,
    output logic [NUM_CH-1:0]    start_o,
    input  logic [NUM_CH-1:0]    busy_i,
    input  logic [NUM_CH-1:0]    done_i,
    output logic                 irq_o
);
    logic [31:0] src_q [NUM_CH];
    logic [31:0] dst_q [NUM_CH];
    logic [15:0] len_q [NUM_CH];
    logic [NUM_CH-1:0] ist_q, ien_q, start_q;
    logic [31:0] rdata_q, mask, wm, rd_val;
    logic rvalid_q, err_q;
    logic [3:0] ch;
    logic [1:0] sel;
    logic is_ver, is_ist, is_ien, ch_hit, busy_sel, cmd_go, wr_err, rd_err;
    logic unused_addr;
    assign unused_addr = ^addr_i[1:0];
    assign mask   = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}}, {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};
    assign wm     = wdata_i & mask;
    assign ch     = addr_i[7:4];
    assign sel    = addr_i[3:2];
    assign is_ver = addr_i[ADDR_W-1:2] == (ADDR_W-2)'(0);
    assign is_ist = addr_i[ADDR_W-1:2] == (ADDR_W-2)'(1);
    assign is_ien = addr_i[ADDR_W-1:2] == (ADDR_W-2)'(2);
    assign ch_hit = addr_i[ADDR_W-1:8] == (ADDR_W-8)'(1) && {1'b0, ch} < 5'(NUM_CH);
    assign cmd_go = wren_i && ch_hit && sel == 2'd3 && wstrb_i[0] && wdata_i[0];
    assign wr_err = wren_i && (!(is_ist || is_ien || ch_hit) || (cmd_go && busy_sel));
    assign rd_err = rden_i && !(is_ver || is_ist || is_ien || ch_hit);
    always_comb begin
        rd_val   = '0;
        busy_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch == 4'(c)) begin
                busy_sel = busy_i[c];
                rd_val   = sel == 2'd0 ? src_q[c] : sel == 2'd1 ? dst_q[c] :
                           sel == 2'd2 ? 32'(len_q[c]) : 32'(busy_i[c]);
            end
        if (!ch_hit)
            rd_val = is_ver ? VERSION : is_ist ? 32'(ist_q) : is_ien ? 32'(ien_q) : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
            ist_q    <= '0;
            ien_q    <= '0;
            start_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // done_i is OR-ed in after the clear so a same-cycle completion wins
            ist_q <= (ist_q & ~((wren_i && is_ist) ? wm[NUM_CH-1:0] : '0)) | done_i;
            if (wren_i && is_ien)
                ien_q <= (ien_q & ~mask[NUM_CH-1:0]) | wm[NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (wren_i && ch_hit && ch == 4'(c)) begin
                    if (sel == 2'd0) src_q[c] <= (src_q[c] & ~mask) | wm;
                    if (sel == 2'd1) dst_q[c] <= (dst_q[c] & ~mask) | wm;
                    if (sel == 2'd2) len_q[c] <= (len_q[c] & ~mask[15:0]) | wm[15:0];
                end
                start_q[c] <= cmd_go && !busy_i[c] && ch == 4'(c);
            end
            rvalid_q <= rden_i;
            err_q    <= wr_err || rd_err;
            if (rden_i)
                rdata_q <= rd_val;
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign src_addr_o[32*g +: 32] = src_q[g];
        assign dst_addr_o[32*g +: 32] = dst_q[g];
        assign byte_len_o[16*g +: 16] = len_q[g];
    end
    assign start_o  = start_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign irq_o    = |(ist_q & ien_q);
endmodule

// File: tb/tb_dmac_cfg_regbank.sv
// tb_dmac_cfg_regbank: directed vector table plus hand sequences for start, interrupt and reset corners
module tb_dmac_cfg_regbank;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 12;
    logic clk = 1'b0;
    logic rst_n, wren_i, rden_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0] wstrb_i;
    logic [31:0] rdata_o;
    logic rvalid_o, err_o, irq_o;
    logic [NUM_CH*32-1:0] src_addr_o, dst_addr_o;
    logic [NUM_CH*16-1:0] byte_len_o;
    logic [NUM_CH-1:0] start_o, busy_i, done_i;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        wr;
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        logic        exp_err;
    } vec_t;
    vec_t vt [17];
    dmac_cfg_regbank #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .VERSION(32'h0001_0000)) dut (
        .clk(clk), .rst_n(rst_n), .wren_i(wren_i), .rden_i(rden_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .err_o(err_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
        .byte_len_o(byte_len_o), .start_o(start_o), .busy_i(busy_i), .done_i(done_i),
        .irq_o(irq_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic wr, input logic rd, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        wren_i = wr; rden_i = rd; addr_i = a; wdata_i = d; wstrb_i = s;
    endtask
    task automatic idle();
        drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask
    initial begin
        vt[0]  = '{1'b0, 1'b1, 12'h000, 32'h0,          4'h0, 32'h0001_0000, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 12'h004, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 12'h100, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 12'h120, 32'hDEAD_BEEF,  4'hF, 32'h0000_0000, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 12'h120, 32'h0000_0011,  4'h1, 32'h0000_0000, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 12'h120, 32'h0,          4'h0, 32'hDEAD_BE11, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 12'h128, 32'hFFFF_1234,  4'hF, 32'hDEAD_BE11, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 12'h128, 32'h0,          4'h0, 32'h0000_1234, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 12'h140, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 12'h000, 32'h1234_5678,  4'hF, 32'h0000_0000, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 12'h000, 32'h0,          4'h0, 32'h0001_0000, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, 12'h104, 32'hFFFF_FFFF,  4'h0, 32'h0001_0000, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 12'h008, 32'hFFFF_FFF5,  4'hF, 32'h0001_0000, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 12'h008, 32'h0,          4'h0, 32'h0000_0005, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b1, 12'h104, 32'h1234_5678,  4'hF, 32'h0000_0000, 1'b1, 1'b0};
        vt[15] = '{1'b0, 1'b1, 12'h104, 32'h0,          4'h0, 32'h1234_5678, 1'b1, 1'b0};
        vt[16] = '{1'b0, 1'b1, 12'h12C, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b0};
        rst_n = 1'b0; busy_i = '0; done_i = '0;
        idle();
        tick(); tick();
        chk("reset_rvalid", 32'(rvalid_o), 32'h0);
        chk("reset_irq", 32'(irq_o), 32'h0);
        chk("reset_start", 32'(start_o), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wstrb);
            tick();
            chk($sformatf("vec%0d_rdata", i), rdata_o, vt[i].exp_rdata);
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid_o), 32'(vt[i].exp_rvalid));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(vt[i].exp_err));
        end
        idle();
        chk("src_ch2_out", src_addr_o[95:64], 32'hDEAD_BE11);
        chk("len_ch2_out", 32'(byte_len_o[47:32]), 32'h0000_1234);
        chk("dst_ch0_out", dst_addr_o[31:0], 32'h1234_5678);
        drive(1'b1, 1'b0, 12'h11C, 32'h1, 4'h1);
        tick();
        idle();
        chk("start_pulse", 32'(start_o), 32'h2);
        chk("start_no_err", 32'(err_o), 32'h0);
        tick();
        chk("start_one_cycle", 32'(start_o), 32'h0);
        busy_i = 4'b0010;
        drive(1'b1, 1'b0, 12'h11C, 32'h1, 4'h1);
        tick();
        idle();
        chk("busy_no_start", 32'(start_o), 32'h0);
        chk("busy_err", 32'(err_o), 32'h1);
        drive(1'b0, 1'b1, 12'h11C, 32'h0, 4'h0);
        tick();
        idle();
        chk("busy_err_one_cycle", 32'(err_o), 32'h0);
        chk("cmd_read_busy", rdata_o, 32'h1);
        busy_i = '0;
        chk("irq_idle", 32'(irq_o), 32'h0);
        done_i = 4'b0011;
        tick();
        done_i = '0;
        chk("irq_set", 32'(irq_o), 32'h1);
        drive(1'b0, 1'b1, 12'h004, 32'h0, 4'h0);
        tick();
        chk("int_status_set", rdata_o, 32'h3);
        drive(1'b1, 1'b0, 12'h004, 32'h1, 4'hF);
        tick();
        idle();
        chk("irq_cleared", 32'(irq_o), 32'h0);
        drive(1'b1, 1'b0, 12'h004, 32'h2, 4'hF);
        done_i = 4'b0010;
        tick();
        done_i = '0;
        drive(1'b0, 1'b1, 12'h004, 32'h0, 4'h0);
        tick();
        idle();
        chk("set_wins_clear", rdata_o, 32'h2);
        drive(1'b0, 1'b1, 12'h000, 32'h0, 4'h0);
        rst_n = 1'b0;
        tick();
        idle();
        chk("rst_read_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_read_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_read_no_late_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_src_cleared", src_addr_o[95:64], 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
